tick_monitor: RTL and testbench

Receive-side companion for tick pulse generators. Watches a single-cycle tick stream and measures the clock-cycle period between ticks. Reports lock when the period matches the expected value, and flags missing ticks (timeout) and off-period ticks (glitches). Sits downstream of any tick source, or in a bench, to supervise sample/strobe timing.

---
 rtl/tick_monitor_if.sv | 30 +++
 rtl/tick_monitor.sv | 138 +++++++++++++
 tb/tb_tick_monitor.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/tick_monitor_if.sv
// Tick stream in, period/lock/timeout status out.
// master: tick source side; slave: the monitor.
interface tick_monitor_if #(
    parameter int WIDTH = 24
);
    logic             tick_i;
    logic [WIDTH-1:0] period_o;
    logic             period_valid_o;
    logic             locked_o;
    logic             timeout_o;
    logic [15:0]      glitch_count_o;

    modport master (
        output tick_i,
        input  period_o,
        input  period_valid_o,
        input  locked_o,
        input  timeout_o,
        input  glitch_count_o
    );

    modport slave (
        input  tick_i,
        output period_o,
        output period_valid_o,
        output locked_o,
        output timeout_o,
        output glitch_count_o
    );
endinterface

// File: rtl/tick_monitor.sv
// Measures the cycle period of a single-cycle tick stream; reports lock,
// timeout and glitches. Ports: clk_i, reset_ni (async, active-low), mon.
module tick_monitor #(
    parameter int WIDTH      = 24,
    parameter int EXPECTED   = 101,
    parameter int TOLERANCE  = 0,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 202
) (
    input logic           clk_i,
    input logic           reset_ni,
    tick_monitor_if.slave mon
);
    localparam int MW = $clog2(LOCK_COUNT + 1);

    localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] HI  = WIDTH'(EXPECTED + TOLERANCE);
    localparam logic [WIDTH-1:0] LO  =
        WIDTH'((EXPECTED > TOLERANCE) ? EXPECTED - TOLERANCE : 0);
    localparam logic [MW-1:0]    LCK = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED,
        LOST
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] elapsed_q, elapsed_d;
    logic [MW-1:0]    match_q, match_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             pvalid_q, pvalid_d;
    logic [15:0]      glitch_q, glitch_d;

    logic          tick;
    logic          in_tol;
    logic          at_tmo;
    logic [MW-1:0] match_inc;

    assign tick      = mon.tick_i;
    assign in_tol    = (elapsed_q >= LO) && (elapsed_q <= HI);
    assign at_tmo    = (elapsed_q == TMO);
    assign match_inc = (match_q == LCK) ? LCK : match_q + 1'b1;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            elapsed_q <= '0;
            match_q   <= '0;
            period_q  <= '0;
            pvalid_q  <= 1'b0;
            glitch_q  <= '0;
        end else begin
            state_q   <= state_d;
            elapsed_q <= elapsed_d;
            match_q   <= match_d;
            period_q  <= period_d;
            pvalid_q  <= pvalid_d;
            glitch_q  <= glitch_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        period_d = period_q;
        pvalid_d = 1'b0;
        glitch_d = glitch_q;

        // IDLE holds 0 until the first tick; a tick always restarts at 1
        // so the next tick reads the full distance.
        if (tick) begin
            elapsed_d = WIDTH'(1);
        end else if (state_q == IDLE) begin
            elapsed_d = '0;
        end else if (at_tmo) begin
            elapsed_d = TMO;
        end else begin
            elapsed_d = elapsed_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = ACQUIRE;
                    match_d = '0;
                end
            end
            ACQUIRE: begin
                if (tick) begin
                    pvalid_d = 1'b1;
                    period_d = elapsed_q;
                    if (in_tol) begin
                        match_d = match_inc;
                        if (match_inc == LCK) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        match_d = '0;
                    end
                end else if (at_tmo) begin
                    state_d = LOST;
                end
            end
            LOCKED: begin
                if (tick) begin
                    pvalid_d = 1'b1;
                    period_d = elapsed_q;
                    if (!in_tol) begin
                        state_d = ACQUIRE;
                        match_d = '0;
                        if (glitch_q != 16'hFFFF) begin
                            glitch_d = glitch_q + 1'b1;
                        end
                    end
                end else if (at_tmo) begin
                    state_d = LOST;
                end
            end
            LOST: begin
                if (tick) begin
                    state_d = ACQUIRE;
                    match_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mon.period_o       = period_q;
    assign mon.period_valid_o = pvalid_q;
    assign mon.locked_o       = (state_q == LOCKED);
    assign mon.timeout_o      = (state_q == LOST);
    assign mon.glitch_count_o = glitch_q;
endmodule

// File: tb/tb_tick_monitor.sv
// Directed bench for tick_monitor: lock, glitch, timeout, boundary,
// stuck-high and asynchronous reset scenarios.
module tb_tick_monitor;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    tick_monitor_if #(.WIDTH(24)) bus ();

    tick_monitor dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .mon      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive tick, take the edge, look 1ns later.
    task automatic step(input logic t);
        bus.tick_i = t;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    // Tick exactly gap cycles after the previous tick.
    task automatic tick_after(input int gap);
        idle(gap - 1);
        step(1'b1);
        bus.tick_i = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.tick_i = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_period", 32'(bus.period_o), 0);
        chk("rst_valid", 32'(bus.period_valid_o), 0);
        chk("rst_locked", 32'(bus.locked_o), 0);
        chk("rst_timeout", 32'(bus.timeout_o), 0);
        chk("rst_glitch", 32'(bus.glitch_count_o), 0);
        rst_n = 1'b1;
        idle(3);

        // Clean stream
        step(1'b1);
        chk("first_valid", 32'(bus.period_valid_o), 0);
        step(1'b0);
        tick_after(100);
        chk("t2_period", 32'(bus.period_o), 101);
        chk("t2_valid", 32'(bus.period_valid_o), 1);
        step(1'b0);
        chk("t2_pulse_end", 32'(bus.period_valid_o), 0);
        tick_after(100);
        chk("t3_period", 32'(bus.period_o), 101);
        tick_after(101);
        chk("t4_locked", 32'(bus.locked_o), 0);
        tick_after(101);
        chk("t5_valid", 32'(bus.period_valid_o), 1);
        chk("t5_locked", 32'(bus.locked_o), 1);

        // Single glitch
        tick_after(100);
        chk("gl_period", 32'(bus.period_o), 100);
        chk("gl_locked", 32'(bus.locked_o), 0);
        chk("gl_count", 32'(bus.glitch_count_o), 1);
        tick_after(101);
        tick_after(101);
        tick_after(101);
        chk("relock_early", 32'(bus.locked_o), 0);
        tick_after(101);
        chk("relock", 32'(bus.locked_o), 1);

        // Tick at the timeout boundary while locked
        tick_after(202);
        chk("bnd_period", 32'(bus.period_o), 202);
        chk("bnd_valid", 32'(bus.period_valid_o), 1);
        chk("bnd_timeout", 32'(bus.timeout_o), 0);
        chk("bnd_locked", 32'(bus.locked_o), 0);
        chk("bnd_glitch", 32'(bus.glitch_count_o), 2);

        // Stopped stream: last tick at t, view is now cycle t+1
        idle(201);
        chk("stop_t202", 32'(bus.timeout_o), 0);
        step(1'b0);
        chk("stop_t203", 32'(bus.timeout_o), 1);
        chk("stop_locked", 32'(bus.locked_o), 0);
        idle(20);
        chk("stop_hold", 32'(bus.timeout_o), 1);
        step(1'b1);
        chk("rec_timeout", 32'(bus.timeout_o), 0);
        chk("rec_valid", 32'(bus.period_valid_o), 0);

        // Stuck-high input
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            chk("stuck_period", 32'(bus.period_o), 1);
            chk("stuck_valid", 32'(bus.period_valid_o), 1);
            chk("stuck_locked", 32'(bus.locked_o), 0);
        end
        bus.tick_i = 1'b0;

        // Relock, then reset between edges
        tick_after(101);
        tick_after(101);
        tick_after(101);
        tick_after(101);
        chk("pre_rst_locked", 32'(bus.locked_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_period", 32'(bus.period_o), 0);
        chk("mid_valid", 32'(bus.period_valid_o), 0);
        chk("mid_locked", 32'(bus.locked_o), 0);
        chk("mid_timeout", 32'(bus.timeout_o), 0);
        chk("mid_glitch", 32'(bus.glitch_count_o), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        step(1'b1);
        chk("post_first_valid", 32'(bus.period_valid_o), 0);
        bus.tick_i = 1'b0;
        tick_after(101);
        chk("post_period", 32'(bus.period_o), 101);
        chk("post_valid", 32'(bus.period_valid_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
